// File: rtl/mul_share_ctrl.sv
// Round-robin front end that shares one pipelined multiplier among NUM_REQ
// requesters, tags results with the requester ID and returns them through a credit-protected FIFO.
module mul_share_ctrl #(
    parameter int WIDTH       = 8,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]          req_a,
    input  logic [NUM_REQ*WIDTH-1:0]          req_b,
    input  logic [NUM_REQ-1:0]                req_unsign,
    output logic [WIDTH-1:0]                  mul_a,
    output logic [WIDTH-1:0]                  mul_b,
    output logic                              mul_unsign,
    input  logic [WIDTH-1:0]                  mul_lower,
    input  logic [WIDTH-1:0]                  mul_upper,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [WIDTH-1:0]                  rsp_lower,
    output logic [WIDTH-1:0]                  rsp_upper,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   credits,
    output logic                              busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_DEPTH);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic             grant_found;
    logic             credit_ok;
    logic             issue;
    logic             pop;
    logic [CNT_W-1:0] used;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             u_q;

    logic             sh_valid;
    logic [ID_W-1:0]  sh_id;

    logic [ID_W-1:0]  id_mem [RESP_DEPTH];
    logic [WIDTH-1:0] lo_mem [RESP_DEPTH];
    logic [WIDTH-1:0] hi_mem [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    // Search upward from ptr+1 so the last winner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    assign pop       = rsp_valid & rsp_ready;
    assign credit_ok = (used < DEPTH_C) | pop;
    assign issue     = grant_found & credit_ok;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (issue) begin
            ptr <= grant_idx;
        end
    end

    // Operands hold their last issued value while idle to avoid toggling the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            u_q <= 1'b0;
        end else if (issue) begin
            a_q <= a_arr[grant_idx];
            b_q <= b_arr[grant_idx];
            u_q <= req_unsign[grant_idx];
        end
    end

    assign mul_a      = issue ? a_arr[grant_idx]      : a_q;
    assign mul_b      = issue ? b_arr[grant_idx]      : b_q;
    assign mul_unsign = issue ? req_unsign[grant_idx] : u_q;

    generate
        if (MUL_LATENCY == 0) begin : g_wire
            assign sh_valid = issue;
            assign sh_id    = grant_idx;
        end else begin : g_pipe
            logic [MUL_LATENCY-1:0] v_q;
            logic [ID_W-1:0]        id_q [MUL_LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                        id_q[i] <= '0;
                    end
                end else begin
                    v_q[0]  <= issue;
                    id_q[0] <= grant_idx;
                    for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                        v_q[i]  <= v_q[i-1];
                        id_q[i] <= id_q[i-1];
                    end
                end
            end

            assign sh_valid = v_q[MUL_LATENCY-1];
            assign sh_id    = id_q[MUL_LATENCY-1];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (sh_valid) begin
            id_mem[wr_ptr] <= sh_id;
            lo_mem[wr_ptr] <= mul_lower;
            hi_mem[wr_ptr] <= mul_upper;
        end
    end

    // Credits reserve FIFO space at issue time, so a push can never find the FIFO full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            used     <= '0;
        end else begin
            if (sh_valid) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (sh_valid && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (!sh_valid && pop) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
            if (issue && !pop) begin
                used <= used + CNT_W'(1);
            end else if (!issue && pop) begin
                used <= used - CNT_W'(1);
            end
        end
    end

    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_id    = id_mem[rd_ptr];
    assign rsp_lower = lo_mem[rd_ptr];
    assign rsp_upper = hi_mem[rd_ptr];
    assign credits   = DEPTH_C - used;
    assign busy      = (used != '0);

    used_bound: assert property (@(posedge clk) disable iff (!rst_n) used <= DEPTH_C);

endmodule
